// File: rtl/memory_responder_if.sv
// memory_responder_if: datapath-side handshake bundle for the wait-state memory responder.
interface memory_responder_if #(parameter int ADDR_W = 9);
    logic [ADDR_W-1:0] MAR_addr;
    logic              Read;
    logic              Write;
    logic [31:0]       Mdatain;
    logic [31:0]       Mdataout;
    logic              Mem_ready;
    logic              Busy;
    logic              Req_err;
    modport master (output MAR_addr, Read, Write, Mdatain, input Mdataout, Mem_ready, Busy, Req_err);
    modport slave (input MAR_addr, Read, Write, Mdatain, output Mdataout, Mem_ready, Busy, Req_err);
endinterface

// File: rtl/memory_responder.sv
// memory_responder: single-port 32-bit word memory answering MAR/MDR requests after WAIT_CYCLES clocks.
module memory_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input logic               clk,
    input logic               clr,
    memory_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t            state, next;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              op_wr;
    logic              start, exec;
    logic [31:0]       mem [2**ADDR_W];
    assign start         = state == IDLE && (bus.Read ^ bus.Write);
    assign exec          = state == ACCESS && cnt == 4'd0;
    assign bus.Busy      = state != IDLE;
    assign bus.Mem_ready = state == DONE;
    always_comb begin
        next = state;
        next = state == IDLE ? (start ? ACCESS : IDLE) : state == ACCESS ? (exec ? DONE : ACCESS) : IDLE;
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            addr         <= '0;
            data         <= '0;
            op_wr        <= 1'b0;
            bus.Mdataout <= '0;
            bus.Req_err  <= 1'b0;
        end else begin
            state       <= next;
            bus.Req_err <= state == IDLE && bus.Read && bus.Write;
            if (start) begin
                addr  <= bus.MAR_addr;
                data  <= bus.Mdatain;
                op_wr <= bus.Write;
                cnt   <= 4'(WAIT_CYCLES - 1);
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (exec && !op_wr) bus.Mdataout <= mem[addr];
        end
    end
    // Memory has no reset; a reset before the execute edge leaves state in IDLE so no write lands.
    always_ff @(posedge clk) begin
        if (exec && op_wr) mem[addr] <= data;
    end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: vector table plus corner sequences; ready-time read data checked from a scoreboard queue.
module tb_memory_responder;
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    memory_responder_if #(.ADDR_W(9)) bus ();
    memory_responder_if #(.ADDR_W(9)) bus1 ();
    memory_responder_if #(.ADDR_W(9)) bus15 ();

    memory_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (.clk(clk), .clr(clr), .bus(bus.slave));
    memory_responder #(.ADDR_W(9), .WAIT_CYCLES(1)) dut1 (.clk(clk), .clr(clr), .bus(bus1.slave));
    memory_responder #(.ADDR_W(9), .WAIT_CYCLES(15)) dut15 (.clk(clk), .clr(clr), .bus(bus15.slave));

    typedef struct {
        logic        wr;
        logic [8:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.Mem_ready) begin
            if (exp_q.size() == 0) check("unexpected_ready", 32'd1, 32'd0);
            else check("ready_dataout", bus.Mdataout, exp_q.pop_front());
        end
    end

    // Called at a negedge; returns at the negedge after the ready pulse has ended.
    task automatic do_access(input logic wr, input logic [8:0] a, input logic [31:0] d, input logic [31:0] exp_d);
        int n = 0;
        bus.Read = !wr;
        bus.Write = wr;
        bus.MAR_addr = a;
        bus.Mdatain = d;
        exp_q.push_back(exp_d);
        @(negedge clk);
        bus.Read = 1'b0;
        bus.Write = 1'b0;
        check("busy_during_access", 32'(bus.Busy), 32'd1);
        while (!bus.Mem_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency_w2", n, 32'd2);
        @(negedge clk);
        check("ready_one_cycle", 32'(bus.Mem_ready), 32'd0);
    endtask

    vec_t vecs [11];

    initial begin
        int n;
        vecs[0]  = '{1'b1, 9'h005, 32'h0000000F, 32'h00000000};
        vecs[1]  = '{1'b0, 9'h005, 32'h00000000, 32'h0000000F};
        vecs[2]  = '{1'b1, 9'h000, 32'hA5A50000, 32'h0000000F};
        vecs[3]  = '{1'b1, 9'h1FF, 32'h00000012, 32'h0000000F};
        vecs[4]  = '{1'b0, 9'h1FF, 32'h00000000, 32'h00000012};
        vecs[5]  = '{1'b0, 9'h000, 32'h00000000, 32'hA5A50000};
        vecs[6]  = '{1'b1, 9'h010, 32'h12345678, 32'hA5A50000};
        vecs[7]  = '{1'b1, 9'h021, 32'h33333333, 32'hA5A50000};
        vecs[8]  = '{1'b0, 9'h010, 32'h00000000, 32'h12345678};
        vecs[9]  = '{1'b1, 9'h0AA, 32'hFFFFFFFF, 32'h12345678};
        vecs[10] = '{1'b0, 9'h0AA, 32'h00000000, 32'hFFFFFFFF};
        {bus.Read, bus.Write, bus.MAR_addr, bus.Mdatain} = '0;
        {bus1.Read, bus1.Write, bus1.MAR_addr, bus1.Mdatain} = '0;
        {bus15.Read, bus15.Write, bus15.MAR_addr, bus15.Mdatain} = '0;
        repeat (2) @(negedge clk);
        check("rst_dataout", bus.Mdataout, 32'h0);
        check("rst_ready", 32'(bus.Mem_ready), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_req_err", 32'(bus.Req_err), 32'd0);
        clr = 1'b1;
        for (int i = 0; i < 11; i++) do_access(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp);

        bus.Read = 1'b1;
        bus.Write = 1'b1;
        bus.MAR_addr = 9'h005;
        bus.Mdatain = 32'h00000BAD;
        @(negedge clk);
        bus.Read = 1'b0;
        bus.Write = 1'b0;
        check("req_err_pulse", 32'(bus.Req_err), 32'd1);
        check("req_err_busy", 32'(bus.Busy), 32'd0);
        @(negedge clk);
        check("req_err_one_cycle", 32'(bus.Req_err), 32'd0);
        check("req_err_still_idle", 32'(bus.Busy), 32'd0);
        do_access(1'b0, 9'h005, 32'h0, 32'h0000000F);

        bus.Read = 1'b1;
        bus.MAR_addr = 9'h005;
        exp_q.push_back(32'h0000000F);
        exp_q.push_back(32'h0000000F);
        for (int p = 0; p < 2; p++) begin
            n = 0;
            @(negedge clk);
            while (!bus.Mem_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("held_read_ready", 32'(bus.Mem_ready), 32'd1);
        end
        bus.Read = 1'b0;
        @(negedge clk);

        bus.Write = 1'b1;
        bus.MAR_addr = 9'h020;
        bus.Mdatain = 32'h11111111;
        exp_q.push_back(32'h0000000F);
        @(negedge clk);
        bus.Write = 1'b0;
        bus.Read = 1'b1;
        bus.MAR_addr = 9'h021;
        bus.Mdatain = 32'h22222222;
        @(negedge clk);
        bus.Read = 1'b0;
        check("ignore_req_err", 32'(bus.Req_err), 32'd0);
        @(negedge clk);
        check("ignore_ready", 32'(bus.Mem_ready), 32'd1);
        check("ignore_req_err2", 32'(bus.Req_err), 32'd0);
        @(negedge clk);
        do_access(1'b0, 9'h020, 32'h0, 32'h11111111);
        do_access(1'b0, 9'h021, 32'h0, 32'h33333333);

        bus.Write = 1'b1;
        bus.MAR_addr = 9'h010;
        bus.Mdatain = 32'hDEADBEEF;
        @(negedge clk);
        bus.Write = 1'b0;
        check("abort_busy_before", 32'(bus.Busy), 32'd1);
        #2 clr = 1'b0;
        #1;
        check("abort_busy", 32'(bus.Busy), 32'd0);
        check("abort_dataout", bus.Mdataout, 32'h0);
        check("abort_ready", 32'(bus.Mem_ready), 32'd0);
        check("abort_req_err", 32'(bus.Req_err), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        do_access(1'b0, 9'h010, 32'h0, 32'h12345678);

        bus1.Write = 1'b1;
        bus1.MAR_addr = 9'h033;
        bus1.Mdatain = 32'h00000005;
        @(negedge clk);
        bus1.Write = 1'b0;
        n = 0;
        while (!bus1.Mem_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency_w1", n, 32'd1);
        @(negedge clk);
        bus1.Read = 1'b1;
        @(negedge clk);
        bus1.Read = 1'b0;
        n = 0;
        while (!bus1.Mem_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("w1_read_data", bus1.Mdataout, 32'h00000005);

        bus15.Write = 1'b1;
        bus15.MAR_addr = 9'h044;
        bus15.Mdatain = 32'h0000ABCD;
        @(negedge clk);
        bus15.Write = 1'b0;
        n = 0;
        while (!bus15.Mem_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency_w15", n, 32'd15);
        @(negedge clk);
        check("w15_ready_one_cycle", 32'(bus15.Mem_ready), 32'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, word-address width (2^ADDR_W x 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, access latency in clocks; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port MAR_addr  input  ADDR_W  word address from the datapath MAR.
REQ-006 SHALL have port Read  input  1  read request, level-sampled in IDLE.
REQ-007 SHALL have port Write  input  1  write request, level-sampled in IDLE.
REQ-008 SHALL have port Mdatain  input  32  write data from the datapath MDR.
REQ-009 SHALL have port Mdataout  output  32  read data, driven into the datapath Mdatain.
REQ-010 SHALL have port Mem_ready  output  1  one-cycle completion pulse for any accepted access.
REQ-011 SHALL have port Busy  output  1  high while an access is in progress (ACCESS or DONE).
REQ-012 SHALL have port Req_err  output  1  one-cycle pulse on a rejected request.

Function
REQ-013 SHALL use a three-state FSM: IDLE, ACCESS, DONE.
REQ-014 IDLE, rising edge, exactly one of Read/Write high: SHALL capture MAR_addr, Mdatain and the op; SHALL load the wait counter with WAIT_CYCLES-1; next state ACCESS.
REQ-015 IDLE, Read and Write both high: request SHALL be rejected; Req_err=1 for the following cycle; state stays IDLE; memory and Mdataout unchanged.
REQ-016 ACCESS: counter SHALL decrement each edge; on the edge where the counter is 0, the captured op SHALL execute and the next state SHALL be DONE.
REQ-017 Write executes as mem[captured addr] <= captured data; Mdataout SHALL be unchanged.
REQ-018 Read executes as Mdataout <= mem[captured addr]; Mdataout SHALL hold that value until the next completed read or reset.
REQ-019 Mem_ready SHALL be 1 only in DONE; DONE SHALL always return to IDLE on the next edge.
REQ-020 Latency: capture at edge k; Mem_ready high from edge k+WAIT_CYCLES to edge k+WAIT_CYCLES+1, exactly one cycle.
REQ-021 Read/Write asserted while Busy SHALL be ignored (no capture, no Req_err); requests still high in IDLE after DONE SHALL start a new access.
REQ-022 Read of an address written by the immediately preceding access SHALL return the new data (no stale read).
REQ-023 Captured address/data SHALL NOT follow MAR_addr/Mdatain changes after capture.
REQ-024 Address arithmetic SHALL be ADDR_W bits unsigned; no wrap or out-of-range case exists since every address maps to a word.
REQ-025 Busy SHALL be combinationally (state != IDLE).

Reset
REQ-026 clr low SHALL asynchronously force state=IDLE, counter=0, Mdataout=0, Mem_ready=0, Req_err=0, captured regs=0.
REQ-027 Reset SHALL NOT alter memory contents; an in-flight write aborted by reset before its execute edge SHALL NOT modify memory.
REQ-028 First request SHALL be accepted on the first rising edge with clr high.

Verification
REQ-029 Write 0x0000000F to addr 0x005, WAIT_CYCLES=2 -> Mem_ready pulses exactly 2 edges after capture, Mdataout stays 0; then Read addr 0x005 -> Mdataout=0x0000000F with Mem_ready.
REQ-030 Back-to-back: Write 0x00000012 to 0x1FF then immediate Read 0x1FF -> Mdataout=0x00000012; address 0x1FF and 0x000 independent.
REQ-031 Read and Write both high in IDLE -> Req_err one-cycle pulse, Busy stays 0, memory unchanged.
REQ-032 Change MAR_addr/Mdatain and toggle Read during ACCESS -> ignored, original access completes with captured values, no Req_err.
REQ-033 Drop clr mid-ACCESS of Write 0xDEADBEEF to 0x010 -> immediate IDLE, outputs 0; later Read 0x010 returns prior contents, not 0xDEADBEEF.
REQ-034 WAIT_CYCLES=1 and 15 -> Mem_ready exactly 1 and 15 edges after capture respectively.
